// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN (stall performance counter).
package pipe_pkg;

    localparam int unsigned REG_AW = 6;

    // aluCtrl value presented to the decode latch when a bubble is inserted.
    localparam logic [9:0] NOP_ALUCTRL = 10'b0;

    typedef enum logic [1:0] {
        StFlush = 2'd0,
        StRun   = 2'd1
    } pipe_state_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
    } sb_entry_t;

endpackage

// File: rtl/pipe_scoreboard.sv
// In-flight destination scoreboard: a DEPTH-entry shift register of pending
// writes plus the source-operand compare that produces the RAW hazard flag.
// Entry 0 is the instruction currently at the decode latch output.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter bit          REG0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              shift_valid,
    input  logic [REG_AW-1:0] shift_dst,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] sel_a,
    input  logic [4:0]        sel_b,
    input  logic              imm_en,
    output logic              hazard
);

    sb_entry_t sb_q [DEPTH];

    // Shift register: newest at entry 0, oldest falls off the end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb_q[i] <= '0;
            end
        end else if (shift_en) begin
            sb_q[0] <= '{valid: shift_valid, dst: shift_dst};
            for (int i = 1; i < DEPTH; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

    // Compare both sources against every pending destination.
    always_comb begin
        logic [REG_AW-1:0] sel_b_ext;
        logic              dst_ok;
        hazard    = 1'b0;
        sel_b_ext = {1'b0, sel_b};
        dst_ok    = 1'b0;
        if (dec_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                // Register 0 is hard-wired, so writes to it never create a dependency.
                dst_ok = sb_q[i].valid && !(REG0_ZERO && (sb_q[i].dst == '0));
                if (dst_ok && (sel_a == sb_q[i].dst)) begin
                    hazard = 1'b1;
                end
                if (dst_ok && !imm_en && (sel_b_ext == sb_q[i].dst)) begin
                    hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: flush sequencer, stall/freeze decode and an
// optional stall counter enabled by the PIPE_HAZARD_CTRL_PERF_EN macro.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter bit          REG0_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    input  logic [5:0]  dec_selA,
    input  logic [4:0]  dec_selB,
    input  logic [5:0]  dec_selOut,
    input  logic        dec_imm_en,
    input  logic        dec_wr,
    input  logic        ex_busy,
    output logic        fetch_en,
    output logic        dec_latch_en,
    output logic        bubble,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt
);

    pipe_state_e state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic        hazard;
    logic        sb_shift_en;
    logic        sb_shift_valid;

    pipe_scoreboard #(
        .DEPTH     (DEPTH),
        .REG0_ZERO (REG0_ZERO)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_en    (sb_shift_en),
        .shift_valid (sb_shift_valid),
        .shift_dst   (dec_selOut),
        .dec_valid   (dec_valid),
        .sel_a       (dec_selA),
        .sel_b       (dec_selB),
        .imm_en      (dec_imm_en),
        .hazard      (hazard)
    );

    // State and flush counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StFlush;
            flush_cnt_q <= 3'(DEPTH);
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state and zero-latency pipeline control decode.
    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        fetch_en       = 1'b0;
        dec_latch_en   = 1'b1;
        bubble         = 1'b1;
        sb_shift_en    = 1'b1;
        sb_shift_valid = 1'b0;
        unique case (state_q)
            StRun: begin
                if (ex_busy) begin
                    // Freeze: hold everything, the latch keeps its contents.
                    dec_latch_en = 1'b0;
                    bubble       = 1'b0;
                    sb_shift_en  = 1'b0;
                end else if (hazard) begin
                    fetch_en = 1'b0;
                end else if (dec_valid) begin
                    fetch_en       = 1'b1;
                    bubble         = 1'b0;
                    sb_shift_valid = dec_wr;
                end else begin
                    fetch_en = 1'b1;
                end
            end
            StFlush: begin
                if (flush_cnt_q == 3'd0) begin
                    state_d = StRun;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d     = StFlush;
                flush_cnt_d = 3'(DEPTH);
            end
        endcase
        // Outputs must show a flush even before the first reset edge lands.
        if (!rst_n) begin
            fetch_en     = 1'b0;
            dec_latch_en = 1'b1;
            bubble       = 1'b1;
        end
    end

    assign state_o = state_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of RUN cycles that did not advance fetch.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == StRun) && !fetch_en && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (DEPTH=2). A second
// instance with REG0_ZERO=0 shares the stimulus for the register-0 case.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid;
    logic [5:0]  dec_selA;
    logic [4:0]  dec_selB;
    logic [5:0]  dec_selOut;
    logic        dec_imm_en;
    logic        dec_wr;
    logic        ex_busy;

    logic        fetch_en0, dec_latch_en0, bubble0;
    logic [1:0]  state0;
    logic [15:0] stall_cnt0;
    logic        fetch_en1, dec_latch_en1, bubble1;
    logic [1:0]  state1;
    logic [15:0] stall_cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DEPTH(2), .REG0_ZERO(1'b1)) dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec_valid    (dec_valid),
        .dec_selA     (dec_selA),
        .dec_selB     (dec_selB),
        .dec_selOut   (dec_selOut),
        .dec_imm_en   (dec_imm_en),
        .dec_wr       (dec_wr),
        .ex_busy      (ex_busy),
        .fetch_en     (fetch_en0),
        .dec_latch_en (dec_latch_en0),
        .bubble       (bubble0),
        .state_o      (state0),
        .stall_cnt    (stall_cnt0)
    );

    pipe_hazard_ctrl #(.DEPTH(2), .REG0_ZERO(1'b0)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec_valid    (dec_valid),
        .dec_selA     (dec_selA),
        .dec_selB     (dec_selB),
        .dec_selOut   (dec_selOut),
        .dec_imm_en   (dec_imm_en),
        .dec_wr       (dec_wr),
        .ex_busy      (ex_busy),
        .fetch_en     (fetch_en1),
        .dec_latch_en (dec_latch_en1),
        .bubble       (bubble1),
        .state_o      (state1),
        .stall_cnt    (stall_cnt1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check {fetch_en, dec_latch_en, bubble} of the REG0_ZERO=1 instance.
    task automatic check_ctl(input string tag, input logic [2:0] exp);
        #1;
        check_eq(tag, {29'd0, fetch_en0, dec_latch_en0, bubble0}, {29'd0, exp});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] a, input logic [4:0] b,
                         input logic [5:0] o, input logic imm, input logic wr);
        dec_valid  = v;
        dec_selA   = a;
        dec_selB   = b;
        dec_selOut = o;
        dec_imm_en = imm;
        dec_wr     = wr;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 6'd1, 5'd2, 6'd3, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        // DEPTH+1 flush cycles
        for (int i = 0; i < 3; i++) cyc();
    endtask

    initial begin
        rst_n   = 1'b0;
        ex_busy = 1'b0;
        drive(1'b0, 6'd1, 5'd2, 6'd3, 1'b0, 1'b0);

        // Reset: outputs flush while held and for 3 cycles after release.
        cyc();
        check_ctl("rst_hold", 3'b011);
        cyc();
        check_eq("rst_state", {30'd0, state0}, 32'd0);
        check_eq("rst_stall", {16'd0, stall_cnt0}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_ctl("flush", 3'b011);
            check_eq("flush_state", {30'd0, state0}, 32'd0);
            cyc();
        end
        check_eq("run_state", {30'd0, state0}, 32'd1);
        check_ctl("run_idle", 3'b111);
        cyc();

        // RAW on source A: 2 stall cycles then issue.
        drive(1'b1, 6'd1, 5'd2, 6'd5, 1'b0, 1'b1);
        check_ctl("raw_issue_w", 3'b110);
        cyc();
        drive(1'b1, 6'd5, 5'd2, 6'd9, 1'b0, 1'b0);
        check_ctl("raw_stall1", 3'b011);
        cyc();
        check_ctl("raw_stall2", 3'b011);
        cyc();
        check_ctl("raw_issue_dep", 3'b110);
        cyc();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        check_eq("raw_stall_cnt", {16'd0, stall_cnt0}, 32'd2);
`else
        check_eq("raw_stall_cnt", {16'd0, stall_cnt0}, 32'd0);
`endif
        idle(2);

        // Immediate replaces source B: no stall.
        drive(1'b1, 6'd1, 5'd2, 6'd7, 1'b0, 1'b1);
        check_ctl("imm_issue_w", 3'b110);
        cyc();
        drive(1'b1, 6'd3, 5'd7, 6'd8, 1'b1, 1'b0);
        check_ctl("imm_nostall", 3'b110);
        cyc();
        idle(2);
        // Same with register source B: 2-cycle stall.
        drive(1'b1, 6'd1, 5'd2, 6'd7, 1'b0, 1'b1);
        cyc();
        drive(1'b1, 6'd3, 5'd7, 6'd8, 1'b0, 1'b0);
        check_ctl("b_stall1", 3'b011);
        cyc();
        check_ctl("b_stall2", 3'b011);
        cyc();
        check_ctl("b_issue", 3'b110);
        cyc();
        idle(2);

        // Freeze during a hazard: scoreboard holds, then 2 stalls remain.
        drive(1'b1, 6'd1, 5'd2, 6'd10, 1'b0, 1'b1);
        cyc();
        drive(1'b1, 6'd10, 5'd2, 6'd8, 1'b0, 1'b0);
        ex_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_ctl("freeze", 3'b000);
            cyc();
        end
        ex_busy = 1'b0;
        check_ctl("frz_stall1", 3'b011);
        cyc();
        check_ctl("frz_stall2", 3'b011);
        cyc();
        check_ctl("frz_issue", 3'b110);
        cyc();
        idle(2);

        // Register 0: ignored with REG0_ZERO=1, tracked with REG0_ZERO=0.
        drive(1'b1, 6'd1, 5'd2, 6'd0, 1'b0, 1'b1);
        cyc();
        drive(1'b1, 6'd0, 5'd2, 6'd8, 1'b0, 1'b0);
        check_ctl("r0_nostall", 3'b110);
        check_eq("r0_dut1_s1", {31'd0, fetch_en1}, 32'd0);
        check_eq("r0_dut1_b1", {31'd0, bubble1}, 32'd1);
        cyc();
        #1;
        check_eq("r0_dut1_s2", {31'd0, fetch_en1}, 32'd0);
        cyc();
        #1;
        check_eq("r0_dut1_go", {31'd0, fetch_en1}, 32'd1);
        cyc();

        // Re-synchronise both instances, then saturate and reset mid-freeze.
        do_reset();
        drive(1'b1, 6'd1, 5'd2, 6'd11, 1'b0, 1'b1);
        cyc();
        drive(1'b1, 6'd11, 5'd2, 6'd8, 1'b0, 1'b0);
        ex_busy = 1'b1;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        force dut0.stall_q = 16'hFFFE;
        #1;
        release dut0.stall_q;
`endif
        for (int i = 0; i < 3; i++) cyc();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        check_eq("sat", {16'd0, stall_cnt0}, 32'h0000FFFF);
`else
        check_eq("sat", {16'd0, stall_cnt0}, 32'd0);
`endif
        rst_n = 1'b0;
        check_ctl("mid_rst_out", 3'b011);
        cyc();
        check_eq("mid_rst_stall", {16'd0, stall_cnt0}, 32'd0);
        check_eq("mid_rst_state", {30'd0, state0}, 32'd0);
        ex_busy = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_ctl("re_flush", 3'b011);
            cyc();
        end
        check_eq("re_run", {30'd0, state0}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
